reg_file_mp: RTL and testbench

Parametrised multi-port register file; successor to the 32x32, 2-read/1-write `reg_file` in the datapath. It adds configurable width, depth, read-port count and write-port count, plus synchronous clearing and a hardwired zero register. It also offers selectable read-during-write policy and optional registered reads. It sits between decode (read addresses) and writeback (write ports) of the multi-issue core.

---
 rtl/reg_file_mp.sv | 85 ++++++++
 tb/tb_reg_file_mp.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: NWR write ports (highest index wins), NRD read ports,
// optional hardwired zero register, selectable read-during-write bypass and optional registered reads.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 0,
  parameter int READ_LAT = 0,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd
);

  logic [XLEN-1:0]     mem_q [NREGS];
  logic [XLEN-1:0]     mem_d [NREGS];
  logic [NRD*XLEN-1:0] rd_d;

  // An address names a real, writable entry: in range and not the hardwired zero.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NWR; i++) begin
      if (we[i] && addr_live(wa[i*AW +: AW])) begin
        mem_d[wa[i*AW +: AW]] = wd[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int j = 0; j < NRD; j++) begin
      if (addr_live(ra[j*AW +: AW])) begin
        rd_d[j*XLEN +: XLEN] = mem_q[ra[j*AW +: AW]];
        if ((BYPASS != 0) && rst_n) begin
          // Later ports overwrite earlier ones, so the highest-index writer is forwarded.
          for (int i = 0; i < NWR; i++) begin
            if (we[i] && (wa[i*AW +: AW] == ra[j*AW +: AW])) begin
              rd_d[j*XLEN +: XLEN] = wd[i*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

  generate
    if (READ_LAT != 0) begin : g_reg_rd
      logic [NRD*XLEN-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_d;
        end
      end
      assign rd = rd_q;
    end else begin : g_comb_rd
      assign rd = rd_d;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: several parameterisations side by side, hand-computed expectations.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Group 1: 32x32, 2R/1W variants sharing one set of inputs
  logic [0:0]  we1 = '0;
  logic [4:0]  wa1 = '0;
  logic [31:0] wd1 = '0;
  logic [9:0]  ra1 = '0;
  logic [63:0] rd_a, rd_b, rd_c, rd_d, rd_g;

  // E: 4 read ports, 3 write ports
  logic [2:0]   we_e = '0;
  logic [14:0]  wa_e = '0;
  logic [95:0]  wd_e = '0;
  logic [19:0]  ra_e = '0;
  logic [127:0] rd_e;

  // F: 20 registers
  logic [0:0]  we_f = '0;
  logic [4:0]  wa_f = '0;
  logic [31:0] wd_f = '0;
  logic [9:0]  ra_f = '0;
  logic [63:0] rd_f;

  reg_file_mp u_a (.clk(clk), .rst_n(rst_n), .we(we1), .wa(wa1), .wd(wd1), .ra(ra1), .rd(rd_a));
  reg_file_mp #(.ZERO_REG(0)) u_b (.clk(clk), .rst_n(rst_n), .we(we1), .wa(wa1), .wd(wd1), .ra(ra1), .rd(rd_b));
  reg_file_mp #(.READ_LAT(1), .BYPASS(0)) u_c (.clk(clk), .rst_n(rst_n), .we(we1), .wa(wa1), .wd(wd1), .ra(ra1), .rd(rd_c));
  reg_file_mp #(.READ_LAT(1), .BYPASS(1)) u_d (.clk(clk), .rst_n(rst_n), .we(we1), .wa(wa1), .wd(wd1), .ra(ra1), .rd(rd_d));
  reg_file_mp #(.BYPASS(1)) u_g (.clk(clk), .rst_n(rst_n), .we(we1), .wa(wa1), .wd(wd1), .ra(ra1), .rd(rd_g));
  reg_file_mp #(.NRD(4), .NWR(3)) u_e (.clk(clk), .rst_n(rst_n), .we(we_e), .wa(wa_e), .wd(wd_e), .ra(ra_e), .rd(rd_e));
  reg_file_mp #(.NREGS(20)) u_f (.clk(clk), .rst_n(rst_n), .we(we_f), .wa(wa_f), .wd(wd_f), .ra(ra_f), .rd(rd_f));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    step();
    step();
    chk("rst_a_rd0", rd_a[31:0], 32'h0);
    chk("rst_c_rd0", rd_c[31:0], 32'h0);
    rst_n = 1'b1;

    // Write DEADBEEF to reg 5, reading reg 5 on lane 0 and reg 7 on lane 1
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEADBEEF; ra1 = {5'd7, 5'd5};
    #1;
    chk("pre_a_old", rd_a[31:0], 32'h0);
    chk("pre_g_fwd", rd_g[31:0], 32'hDEADBEEF);
    step();
    chk("w1_a_rd0", rd_a[31:0], 32'hDEADBEEF);
    chk("w1_c_old", rd_c[31:0], 32'h0);
    chk("w1_d_fwd", rd_d[31:0], 32'hDEADBEEF);

    // Overwrite reg 5 with CAFEBABE
    wd1 = 32'hCAFEBABE;
    step();
    chk("w2_a_rd0", rd_a[31:0], 32'hCAFEBABE);
    chk("w2_c_old", rd_c[31:0], 32'hDEADBEEF);
    chk("w2_d_fwd", rd_d[31:0], 32'hCAFEBABE);
    we1 = 1'b0;
    step();
    chk("w3_c_new", rd_c[31:0], 32'hCAFEBABE);
    chk("w3_c_rd1", rd_c[63:32], 32'h0);

    // Zero register
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h12345678; ra1 = {5'd0, 5'd0};
    #1;
    chk("z_g_nofwd", rd_g[31:0], 32'h0);
    step();
    we1 = 1'b0;
    #1;
    chk("z_a_rd0", rd_a[31:0], 32'h0);
    chk("z_a_rd1", rd_a[63:32], 32'h0);
    chk("z_b_rd0", rd_b[31:0], 32'h12345678);
    chk("z_d_rd0", rd_d[31:0], 32'h0);

    // Reset coincident with a write to reg 9
    rst_n = 1'b0; we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h55; ra1 = {5'd9, 5'd5};
    #1;
    chk("rmid_g_nofwd", rd_g[63:32], 32'h0);
    chk("rmid_g_old5", rd_g[31:0], 32'hCAFEBABE);
    step();
    rst_n = 1'b1; we1 = 1'b0;
    #1;
    chk("rmid_a_rd0", rd_a[31:0], 32'h0);
    chk("rmid_a_rd1", rd_a[63:32], 32'h0);
    chk("rmid_b_rd0", rd_b[31:0], 32'h0);
    chk("rmid_c_rd0", rd_c[31:0], 32'h0);
    step();
    chk("rmid_c_rd1", rd_c[63:32], 32'h0);

    // Write-write conflict on reg 7
    we_e = 3'b111; wa_e = {5'd7, 5'd7, 5'd7}; wd_e = {32'h3, 32'h2, 32'h1};
    ra_e = {5'd7, 5'd7, 5'd7, 5'd7};
    step();
    we_e = 3'b000;
    #1;
    chk("wconf_3", rd_e[31:0], 32'h3);
    chk("wconf_3_l3", rd_e[127:96], 32'h3);
    we_e = 3'b011;
    step();
    we_e = 3'b000;
    #1;
    chk("wconf_2", rd_e[31:0], 32'h2);

    // Parallel ports
    we_e = 3'b011; wa_e = {5'd0, 5'd9, 5'd3}; wd_e = {32'h0, 32'hB, 32'hA};
    ra_e = {5'd0, 5'd3, 5'd9, 5'd3};
    step();
    we_e = 3'b000;
    #1;
    chk("par_l0", rd_e[31:0], 32'hA);
    chk("par_l1", rd_e[63:32], 32'hB);
    chk("par_l2", rd_e[95:64], 32'hA);
    chk("par_l3", rd_e[127:96], 32'h0);

    // Non-power-of-two depth
    we_f = 1'b1; wa_f = 5'd25; wd_f = 32'hFF; ra_f = {5'd19, 5'd25};
    step();
    chk("np2_oob", rd_f[31:0], 32'h0);
    wa_f = 5'd19;
    step();
    we_f = 1'b0;
    #1;
    chk("np2_last", rd_f[63:32], 32'hFF);
    chk("np2_oob2", rd_f[31:0], 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
